ps2_host_tx: RTL

Host-to-device PS/2 transmitter that sends one command byte per request to the keyboard (e.g. 0xED set-LEDs, 0xFF reset). It is the transmit side of the keyboard port, complementing the existing PS/2 receive path inside the memory-mapped I/O unit. It shares the open-collector `kbd_clk`/`kbd_data` lines with that path. The block drives the lines only through active-high pull-low enables; the top level converts each enable to `1'b0 : 1'bz`. It asserts `busy` so the receive path discards frames while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte per request over the
// shared open-collector keyboard lines using active-high pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       kbd_clk_in,
    input  logic       kbd_data_in,
    output logic       kbd_clk_oe,
    output logic       kbd_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [9:0]       r_frame;
    logic             r_nack, w_nack_nxt;
    logic             r_clk_s1, r_clk_s2, r_clk_d;
    logic             r_data_s1, r_data_s2;
    logic             r_ready, r_busy, r_done, r_error, r_clk_oe, r_data_oe;
    logic             w_data_oe_nxt, w_done_nxt, w_error_nxt;
    logic             w_shift, w_accept, w_fall, w_timeout;

    assign w_accept  = tx_valid && r_ready;
    assign w_fall    = r_clk_d && !r_clk_s2;
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    // Idle lines float high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_d   <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= kbd_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_clk_d   <= r_clk_s2;
            r_data_s1 <= kbd_data_in;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_nack    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_nack    <= w_nack_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_clk_oe  <= (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_START);
            r_data_oe <= w_data_oe_nxt;
        end
    end

    // Frame is {stop, parity, data}; bit 0 is the next bit to put on the line.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame <= {1'b1, ~^tx_data, tx_data};
        end else if (w_shift) begin
            r_frame <= {1'b1, r_frame[9:1]};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_nack_nxt    = r_nack;
        w_data_oe_nxt = r_data_oe;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt   = S_INHIBIT;
                    w_cnt_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                    w_nack_nxt    = 1'b0;
                end
            end
            S_INHIBIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == INHIBIT_LAST) begin
                    w_state_nxt   = S_START;
                    w_data_oe_nxt = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = '0;
            end
            S_SHIFT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_data_oe_nxt = 1'b0;
                    w_error_nxt   = 1'b1;
                end else if (w_fall) begin
                    w_shift       = 1'b1;
                    w_data_oe_nxt = ~r_frame[0];
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_cnt_nxt     = r_cnt + 1'b1;
                w_data_oe_nxt = 1'b0;
                // Timeout wins over an ACK edge arriving in the same cycle.
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_fall) begin
                    w_nack_nxt  = r_data_s2;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (r_clk_s2 && r_data_s2) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = !r_nack;
                    w_error_nxt = r_nack;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = r_ready;
    assign busy        = r_busy;
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign kbd_clk_oe  = r_clk_oe;
    assign kbd_data_oe = r_data_oe;

endmodule
